// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the hardwired control sequencer:
// state and opcode-class enums, opcode numbers, ALU codes and MDR source selects.
package ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7,
    ST_HALTED, ST_FAULT, ST_PAUSE
  } state_e;

  typedef enum logic [2:0] {
    CL_LD, CL_LDI, CL_ST, CL_RR, CL_RI, CL_NOP, CL_HALT, CL_ILL
  } opc_class_e;

  localparam logic [31:0] OP_LD   = 32'd0;
  localparam logic [31:0] OP_LDI  = 32'd1;
  localparam logic [31:0] OP_ST   = 32'd2;
  localparam logic [31:0] OP_ADD  = 32'd3;
  localparam logic [31:0] OP_SUB  = 32'd4;
  localparam logic [31:0] OP_AND  = 32'd5;
  localparam logic [31:0] OP_OR   = 32'd6;
  localparam logic [31:0] OP_ADDI = 32'd7;
  localparam logic [31:0] OP_ANDI = 32'd8;
  localparam logic [31:0] OP_ORI  = 32'd9;
  localparam logic [31:0] OP_NOP  = 32'd26;
  localparam logic [31:0] OP_HALT = 32'd27;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd3;

  localparam logic [1:0] MDR_HOLD = 2'b00;
  localparam logic [1:0] MDR_MEM  = 2'b01;
  localparam logic [1:0] MDR_BUS  = 2'b10;

  function automatic opc_class_e classify(input logic [31:0] opc);
    opc_class_e cls;
    case (opc)
      OP_LD:                                cls = CL_LD;
      OP_LDI:                               cls = CL_LDI;
      OP_ST:                                cls = CL_ST;
      OP_ADD, OP_SUB, OP_AND, OP_OR:        cls = CL_RR;
      OP_ADDI, OP_ANDI, OP_ORI:             cls = CL_RI;
      OP_NOP:                               cls = CL_NOP;
      OP_HALT:                              cls = CL_HALT;
      default:                              cls = CL_ILL;
    endcase
    return cls;
  endfunction

  // Address arithmetic for LD/LDI/ST goes through the ADD path as well.
  function automatic logic [3:0] alu_code(input logic [31:0] opc);
    logic [3:0] code;
    case (opc)
      OP_SUB:           code = ALU_SUB;
      OP_AND, OP_ANDI:  code = ALU_AND;
      OP_OR,  OP_ORI:   code = ALU_OR;
      default:          code = ALU_ADD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/ctrl_wait_timer.sv
// Memory-handshake wait counter shared by every mem_ready wait step.
// Counts waiting cycles from zero; timeout fires in the MEM_WAIT-th cycle if mem_ready is still low.
module ctrl_wait_timer #(
  parameter int MEM_WAIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic en_i,
  input  logic ready_i,
  output logic done_o,
  output logic timeout_o
);

  localparam int CNT_W = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
  localparam logic [CNT_W-1:0] TC = CNT_W'(MEM_WAIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && !ready_i && (cnt_q != TC)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A ready seen in the terminal-count cycle still wins over the timeout.
  assign done_o    = en_i && ready_i;
  assign timeout_o = en_i && !ready_i && (cnt_q == TC);

endmodule

// File: rtl/ctrl_sequencer.sv
// Hardwired control unit: fetch T0-T2, per-opcode execute T3-T7, Moore strobes from state + latched opcode.
// Optional build macro CTRL_SINGLE_STEP_EN adds step_req and a PAUSE state after every instruction.
//
//  state   | meaning
//  IDLE    | no strobes, waiting for run
//  T0..T2  | fetch (T1 waits on mem_ready)
//  T3..T7  | execute, per opcode class (LD T6 / ST T7 wait on mem_ready)
//  HALTED  | sticky after HALT, exit by reset only
//  FAULT   | sticky after memory timeout, exit by reset only
//  PAUSE   | single-step build only: parked after instr_done until step_req
module ctrl_sequencer
  import ctrl_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int OPC_W      = 5,
  parameter int ALU_CTRL_W = 4,
  parameter int MEM_WAIT   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  input  logic [DATA_W-1:0]     ir,
  input  logic                  mem_ready,
`ifdef CTRL_SINGLE_STEP_EN
  input  logic                  step_req,
`endif
  output logic                  PCout,
  output logic                  PCin,
  output logic                  IncPc,
  output logic                  MARin,
  output logic                  MDRin,
  output logic                  MDRout,
  output logic                  IRin,
  output logic                  Yin,
  output logic                  Zlowin,
  output logic                  Zlowout,
  output logic                  GRA,
  output logic                  GRB,
  output logic                  GRC,
  output logic                  Rin,
  output logic                  Rout,
  output logic                  BAout,
  output logic                  Cout,
  output logic                  read,
  output logic                  write,
  output logic [1:0]            mdr_read,
  output logic [ALU_CTRL_W-1:0] alu_ctrl,
  output logic                  instr_done,
  output logic                  halted,
  output logic                  illegal,
  output logic                  fault
);

  state_e           state_q, state_d, end_state;
  logic [OPC_W-1:0] opc_q, opc_d;
  opc_class_e       cls;
  logic [31:0]      opc_ext;
  logic             waiting, tmr_done, tmr_timeout;
  logic             unused_ir;

  assign unused_ir = ^ir[DATA_W-OPC_W-1:0];
  assign opc_ext   = 32'(opc_q);
  assign cls       = classify(opc_ext);

  assign waiting = (state_q == ST_T1) ||
                   ((state_q == ST_T6) && (cls == CL_LD)) ||
                   ((state_q == ST_T7) && (cls == CL_ST));

  ctrl_wait_timer #(.MEM_WAIT(MEM_WAIT)) u_wait_timer (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (!waiting),
    .en_i      (waiting),
    .ready_i   (mem_ready),
    .done_o    (tmr_done),
    .timeout_o (tmr_timeout)
  );

  // IR captures the bus on the edge closing T2; the opcode is taken on that same edge.
  assign opc_d = (state_q == ST_T2) ? ir[DATA_W-1 -: OPC_W] : opc_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      opc_q   <= '0;
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
    end
  end

  always_comb begin
`ifdef CTRL_SINGLE_STEP_EN
    end_state = ST_PAUSE;
`else
    end_state = run ? ST_T0 : ST_IDLE;
`endif
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (run) state_d = ST_T0;
      ST_T0:   state_d = ST_T1;
      ST_T1: begin
        if (tmr_done)         state_d = ST_T2;
        else if (tmr_timeout) state_d = ST_FAULT;
      end
      ST_T2:   state_d = ST_T3;
      ST_T3: begin
        case (cls)
          CL_HALT:       state_d = ST_HALTED;
          CL_NOP, CL_ILL: state_d = end_state;
          default:       state_d = ST_T4;
        endcase
      end
      ST_T4:   state_d = ST_T5;
      ST_T5:   state_d = ((cls == CL_LD) || (cls == CL_ST)) ? ST_T6 : end_state;
      ST_T6: begin
        if (cls != CL_LD)     state_d = ST_T7;
        else if (tmr_done)    state_d = ST_T7;
        else if (tmr_timeout) state_d = ST_FAULT;
      end
      ST_T7: begin
        if (cls != CL_ST)     state_d = end_state;
        else if (tmr_done)    state_d = end_state;
        else if (tmr_timeout) state_d = ST_FAULT;
      end
`ifdef CTRL_SINGLE_STEP_EN
      ST_PAUSE: if (step_req) state_d = run ? ST_T0 : ST_IDLE;
`endif
      default: state_d = state_q;
    endcase
  end

  always_comb begin
    PCout      = 1'b0;
    PCin       = 1'b0;
    IncPc      = 1'b0;
    MARin      = 1'b0;
    MDRin      = 1'b0;
    MDRout     = 1'b0;
    IRin       = 1'b0;
    Yin        = 1'b0;
    Zlowin     = 1'b0;
    Zlowout    = 1'b0;
    GRA        = 1'b0;
    GRB        = 1'b0;
    GRC        = 1'b0;
    Rin        = 1'b0;
    Rout       = 1'b0;
    BAout      = 1'b0;
    Cout       = 1'b0;
    read       = 1'b0;
    write      = 1'b0;
    mdr_read   = MDR_HOLD;
    alu_ctrl   = '0;
    instr_done = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      ST_T0: begin
        PCout = 1'b1; MARin = 1'b1; IncPc = 1'b1; Zlowin = 1'b1;
      end
      ST_T1: begin
        Zlowout = 1'b1; PCin = 1'b1; read = 1'b1; mdr_read = MDR_MEM; MDRin = 1'b1;
      end
      ST_T2: begin
        MDRout = 1'b1; IRin = 1'b1;
      end
      ST_T3: begin
        case (cls)
          CL_LD, CL_LDI, CL_ST: begin GRB = 1'b1; BAout = 1'b1; Yin = 1'b1; end
          CL_RR, CL_RI:         begin GRB = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          CL_ILL:               begin illegal = 1'b1; instr_done = 1'b1; end
          default:              instr_done = 1'b1;
        endcase
      end
      ST_T4: begin
        Zlowin   = 1'b1;
        alu_ctrl = ALU_CTRL_W'(alu_code(opc_ext));
        if (cls == CL_RR) begin
          GRC = 1'b1; Rout = 1'b1;
        end else begin
          Cout = 1'b1;
        end
      end
      ST_T5: begin
        Zlowout = 1'b1;
        if ((cls == CL_LD) || (cls == CL_ST)) begin
          MARin = 1'b1;
        end else begin
          GRA = 1'b1; Rin = 1'b1; instr_done = 1'b1;
        end
      end
      ST_T6: begin
        MDRin = 1'b1;
        if (cls == CL_LD) begin
          read = 1'b1; mdr_read = MDR_MEM;
        end else begin
          GRA = 1'b1; Rout = 1'b1; mdr_read = MDR_BUS;
        end
      end
      ST_T7: begin
        if (cls == CL_LD) begin
          MDRout = 1'b1; GRA = 1'b1; Rin = 1'b1; instr_done = 1'b1;
        end else begin
          // The store only completes in the cycle memory acknowledges it.
          write = 1'b1; instr_done = tmr_done;
        end
      end
      default: ;
    endcase
  end

  assign halted = (state_q == ST_HALTED);
  assign fault  = (state_q == ST_FAULT);

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Self-checking bench for ctrl_sequencer: per-instruction expected strobe vectors built
// from the step table, random memory delays/opcodes, plus reset, fault and halt scenarios.
module tb_ctrl_sequencer;
  localparam int MEM_WAIT = 16;

  logic        clk = 1'b0;
  logic        reset, run, mem_ready;
  logic [31:0] ir;
`ifdef CTRL_SINGLE_STEP_EN
  logic        step_req;
`endif
  logic PCout, PCin, IncPc, MARin, MDRin, MDRout, IRin, Yin, Zlowin, Zlowout;
  logic GRA, GRB, GRC, Rin, Rout, BAout, Cout, read, write;
  logic [1:0] mdr_read;
  logic [3:0] alu_ctrl;
  logic instr_done, halted, illegal, fault;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ctrl_sequencer #(.DATA_W(32), .OPC_W(5), .ALU_CTRL_W(4), .MEM_WAIT(MEM_WAIT)) dut (
    .clk(clk), .reset(reset), .run(run), .ir(ir), .mem_ready(mem_ready),
`ifdef CTRL_SINGLE_STEP_EN
    .step_req(step_req),
`endif
    .PCout(PCout), .PCin(PCin), .IncPc(IncPc), .MARin(MARin), .MDRin(MDRin),
    .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zlowin(Zlowin), .Zlowout(Zlowout),
    .GRA(GRA), .GRB(GRB), .GRC(GRC), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .Cout(Cout), .read(read), .write(write), .mdr_read(mdr_read), .alu_ctrl(alu_ctrl),
    .instr_done(instr_done), .halted(halted), .illegal(illegal), .fault(fault)
  );

  logic [28:0] obs;
  assign obs = {PCout, PCin, IncPc, MARin, MDRin, MDRout, IRin, Yin, Zlowin, Zlowout,
                GRA, GRB, GRC, Rin, Rout, BAout, Cout, read, write,
                mdr_read, alu_ctrl, instr_done, illegal, halted, fault};

  localparam logic [28:0] PCOUT = 29'h1 << 28, PCIN = 29'h1 << 27, INCPC = 29'h1 << 26;
  localparam logic [28:0] MARIN = 29'h1 << 25, MDRIN = 29'h1 << 24, MDROUT = 29'h1 << 23;
  localparam logic [28:0] IRIN = 29'h1 << 22, YIN = 29'h1 << 21, ZLOWIN = 29'h1 << 20;
  localparam logic [28:0] ZLOWOUT = 29'h1 << 19, GRA_B = 29'h1 << 18, GRB_B = 29'h1 << 17;
  localparam logic [28:0] GRC_B = 29'h1 << 16, RIN = 29'h1 << 15, ROUT = 29'h1 << 14;
  localparam logic [28:0] BAOUT = 29'h1 << 13, COUT = 29'h1 << 12, READ = 29'h1 << 11;
  localparam logic [28:0] WRITE = 29'h1 << 10, MDR_MEM = 29'h1 << 8, MDR_BUS = 29'h2 << 8;
  localparam logic [28:0] DONE = 29'h1 << 3, ILL = 29'h1 << 2, HALT = 29'h1 << 1, FLT = 29'h1;

  typedef struct { logic [28:0] v; int wk; bit done_rdy; } step_t;
  step_t steps[$];

  function automatic logic [28:0] alu_f(input int code);
    return 29'(code) << 4;
  endfunction

  task automatic add(input logic [28:0] v, input int wk = 0, input bit dr = 1'b0);
    step_t s;
    s.v = v; s.wk = wk; s.done_rdy = dr;
    steps.push_back(s);
  endtask

  // Expected step list straight from the instruction table (wk: 1 fetch wait, 2 execute wait).
  task automatic build(input int opc);
    int a;
    steps.delete();
    add(PCOUT | MARIN | INCPC | ZLOWIN);
    add(ZLOWOUT | PCIN | READ | MDR_MEM | MDRIN, 1);
    add(MDROUT | IRIN);
    if (opc <= 2) begin
      add(GRB_B | BAOUT | YIN);
      add(COUT | alu_f(2) | ZLOWIN);
      if (opc == 1) add(ZLOWOUT | GRA_B | RIN | DONE);
      else begin
        add(ZLOWOUT | MARIN);
        if (opc == 0) begin
          add(READ | MDR_MEM | MDRIN, 2);
          add(MDROUT | GRA_B | RIN | DONE);
        end else begin
          add(GRA_B | ROUT | MDR_BUS | MDRIN);
          add(WRITE, 2, 1'b1);
        end
      end
    end else if (opc <= 9) begin
      a = (opc == 3 || opc == 7) ? 2 : (opc == 4) ? 3 : (opc == 5 || opc == 8) ? 0 : 1;
      add(GRB_B | ROUT | YIN);
      if (opc <= 6) add(GRC_B | ROUT | alu_f(a) | ZLOWIN);
      else          add(COUT | alu_f(a) | ZLOWIN);
      add(ZLOWOUT | GRA_B | RIN | DONE);
    end else if (opc == 26 || opc == 27) begin
      add(DONE);
    end else begin
      add(ILL | DONE);
    end
  endtask

  // Runs one instruction from its T0 cycle; dly < 0 on the execute wait means memory never answers.
  task automatic run_instr(input int opc, input int dly_f, input int dly_e,
                           input bit drop_run, input int stop_at);
    logic [28:0] want;
    int d, n;
    build(opc);
    ir = {opc[4:0], 27'($urandom)};
    for (int s = 0; s < steps.size(); s++) begin
      d = (steps[s].wk == 1) ? dly_f : (steps[s].wk == 2) ? dly_e : 0;
      n = (steps[s].wk == 0) ? 1 : (d < 0) ? MEM_WAIT : d + 1;
      for (int k = 0; k < n; k++) begin
        @(negedge clk);
        mem_ready = (steps[s].wk != 0) ? (k == d) : 1'($urandom);
        if (drop_run && s == 2) run = 1'b0;
        #1;
        want = steps[s].v | ((steps[s].done_rdy && mem_ready) ? DONE : 29'h0);
        checks++;
        if (obs !== want) begin
          failures++;
          $display("FAIL instr_step opc=%0d step=%0d cyc=%0d got=%h want=%h", opc, s, k, obs, want);
        end
      end
      if (steps[s].wk != 0 && d < 0) return;
      if (s == stop_at) return;
    end
`ifdef CTRL_SINGLE_STEP_EN
    if (opc != 27) begin
      repeat (2) begin
        @(negedge clk); mem_ready = 1'($urandom); #1;
        checks++;
        if (obs !== 29'h0) begin
          failures++;
          $display("FAIL pause_hold opc=%0d got=%h want=%h", opc, obs, 29'h0);
        end
      end
      @(negedge clk); step_req = 1'b1; #1;
      checks++;
      if (obs !== 29'h0) begin
        failures++;
        $display("FAIL pause_step opc=%0d got=%h want=%h", opc, obs, 29'h0);
      end
      @(posedge clk); #1 step_req = 1'b0;
    end
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; run = 1'b0; mem_ready = 1'b0; ir = '0;
`ifdef CTRL_SINGLE_STEP_EN
    step_req = 1'b0;
`endif
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if (obs !== 29'h0) begin
      failures++;
      $display("FAIL reset_outputs got=%h want=%h", obs, 29'h0);
    end
    repeat (3) begin
      @(negedge clk); mem_ready = 1'($urandom); #1;
      checks++;
      if (obs !== 29'h0) begin
        failures++;
        $display("FAIL idle_no_run got=%h want=%h", obs, 29'h0);
      end
    end
  endtask

  task automatic test_ldi_and_ld_wait();
    do_reset();
    run = 1'b1;
    run_instr(1, 0, 0, 1'b0, -1);
    run_instr(0, 0, 3, 1'b0, -1);
    run_instr(2, 2, 1, 1'b0, -1);
  endtask

  task automatic test_st_fault();
    do_reset();
    run = 1'b1;
    run_instr(2, 1, -1, 1'b0, -1);
    repeat (5) begin
      @(negedge clk); run = 1'($urandom); mem_ready = 1'($urandom); #1;
      checks++;
      if (obs !== FLT) begin
        failures++;
        $display("FAIL st_fault got=%h want=%h", obs, FLT);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    run = 1'b1;
    run_instr(3, 0, 0, 1'b0, 4);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (obs !== 29'h0) begin
      failures++;
      $display("FAIL async_reset got=%h want=%h", obs, 29'h0);
    end
    @(negedge clk); reset = 1'b0; #1;
    checks++;
    if (obs !== 29'h0) begin
      failures++;
      $display("FAIL post_reset_idle got=%h want=%h", obs, 29'h0);
    end
    run_instr(3, 0, 0, 1'b0, -1);
    run_instr(7, 1, 0, 1'b0, -1);
  endtask

  task automatic test_illegal();
    do_reset();
    run = 1'b1;
    run_instr(31, 0, 0, 1'b0, -1);
    run_instr(1, 0, 0, 1'b0, -1);
    run_instr(26, 2, 0, 1'b0, -1);
    run_instr(12, 0, 0, 1'b0, -1);
  endtask

  task automatic test_halt();
    do_reset();
    run = 1'b1;
    run_instr(27, 1, 0, 1'b0, -1);
    repeat (8) begin
      @(negedge clk); run = 1'($urandom); mem_ready = 1'($urandom); #1;
      checks++;
      if (obs !== HALT) begin
        failures++;
        $display("FAIL halt_sticky got=%h want=%h", obs, HALT);
      end
    end
  endtask

  task automatic test_random();
    int opc, pick;
    bit drop;
    do_reset();
    run = 1'b1;
    for (int i = 0; i < 40; i++) begin
      pick = $urandom_range(0, 11);
      if (pick <= 9)       opc = pick;
      else if (pick == 10) opc = 26;
      else                 opc = $urandom_range(0, 1) ? $urandom_range(10, 25) : $urandom_range(28, 31);
      drop = ($urandom_range(0, 5) == 0);
      run_instr(opc, $urandom_range(0, 3), $urandom_range(0, 3), drop, -1);
      if (drop) begin
        @(negedge clk); mem_ready = 1'($urandom); #1;
        checks++;
        if (obs !== 29'h0) begin
          failures++;
          $display("FAIL run_drop_idle opc=%0d got=%h want=%h", opc, obs, 29'h0);
        end
        run = 1'b1;
      end
    end
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; mem_ready = 1'b0; ir = '0;
`ifdef CTRL_SINGLE_STEP_EN
    step_req = 1'b0;
`endif
    test_reset();
    test_ldi_and_ld_wait();
    test_st_fault();
    test_reset_mid();
    test_illegal();
    test_halt();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

endmodule
